vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl.sv | 104 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 style raster timing generator: a clock divider produces the pixel tick,
// and every output is registered from the position that tick moves to.
module vga_timing_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       bright,
   output logic       hSync,
   output logic       vSync,
   output logic       pix_en,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
   localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_cnt_r;
   logic             tick_s;
   logic [9:0]       h_nxt_s;
   logic [9:0]       v_nxt_s;
   logic             bright_s;
   logic             hsync_s;
   logic             vsync_s;
   logic             origin_s;

   // Next raster position and the decoded outputs that belong to it.
   always_comb begin
      tick_s  = (div_cnt_r == DIV_LAST);
      h_nxt_s = hCount;
      v_nxt_s = vCount;
      if (hCount == H_LAST) begin
         h_nxt_s = 10'd0;
         if (vCount == V_LAST) begin
            v_nxt_s = 10'd0;
         end else begin
            v_nxt_s = vCount + 10'd1;
         end
      end else begin
         h_nxt_s = hCount + 10'd1;
      end
      bright_s = (h_nxt_s < H_VIS_L) && (v_nxt_s < V_VIS_L);
      hsync_s  = ~((h_nxt_s >= H_SYNC_BEG) && (h_nxt_s < H_SYNC_END));
      vsync_s  = ~((v_nxt_s >= V_SYNC_BEG) && (v_nxt_s < V_SYNC_END));
      origin_s = (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
   end

   // Pixel-rate divider.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
      end
   end

   // Reset parks the raster on the last pixel so the first tick lands on (0,0).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hCount      <= H_LAST;
         vCount      <= V_LAST;
         bright      <= 1'b0;
         hSync       <= 1'b1;
         vSync       <= 1'b1;
         pix_en      <= 1'b0;
         frame_start <= 1'b0;
      end else if (tick_s) begin
         hCount      <= h_nxt_s;
         vCount      <= v_nxt_s;
         bright      <= bright_s;
         hSync       <= hsync_s;
         vSync       <= vsync_s;
         pix_en      <= 1'b1;
         frame_start <= origin_s;
      end else begin
         pix_en      <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a pixel-count model pushes expected raster states per tick,
// a negedge monitor compares every output of four differently-parameterised instances.
module tb_vga_timing_ctrl;

   localparam int N = 4;
   localparam int CD [N] = '{4, 2, 3, 16};
   localparam int HV [N] = '{640, 640, 8, 8};
   localparam int HF [N] = '{16, 16, 2, 2};
   localparam int HS [N] = '{96, 96, 3, 3};
   localparam int HB [N] = '{48, 48, 2, 2};
   localparam int VV [N] = '{480, 480, 5, 5};
   localparam int VF [N] = '{10, 10, 1, 1};
   localparam int VS [N] = '{2, 2, 2, 2};
   localparam int VB [N] = '{33, 33, 1, 1};

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       b;
      logic       hs;
      logic       vs;
      logic       pe;
      logic       fs;
   } obs_t;

   typedef struct {
      int   inst;
      obs_t o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] hc [N];
   logic [9:0] vc [N];
   logic       br [N];
   logic       hsy [N];
   logic       vsy [N];
   logic       pe [N];
   logic       fs [N];

   int   checks   = 0;
   int   failures = 0;
   int   edges    = 0;
   exp_t sb [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      vga_timing_ctrl #(
         .CLK_DIV(CD[g]), .H_VIS(HV[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
         .V_VIS(VV[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g])
      ) u_dut (
         .clk(clk), .reset(rst), .hCount(hc[g]), .vCount(vc[g]), .bright(br[g]),
         .hSync(hsy[g]), .vSync(vsy[g]), .pix_en(pe[g]), .frame_start(fs[g])
      );
   end

   function automatic obs_t model_obs(int i, int n);
      obs_t o;
      int ht, vt, p, h, v;
      ht = HV[i] + HF[i] + HS[i] + HB[i];
      vt = VV[i] + VF[i] + VS[i] + VB[i];
      p  = (n - 1) % (ht * vt);
      h  = p % ht;
      v  = p / ht;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.b  = (h < HV[i]) && (v < VV[i]);
      o.hs = !((h >= HV[i] + HF[i]) && (h < HV[i] + HF[i] + HS[i]));
      o.vs = !((v >= VV[i] + VF[i]) && (v < VV[i] + VF[i] + VS[i]));
      o.pe = 1'b1;
      o.fs = (p == 0);
      return o;
   endfunction

   function automatic obs_t reset_obs(int i);
      obs_t o;
      o.h  = 10'(HV[i] + HF[i] + HS[i] + HB[i] - 1);
      o.v  = 10'(VV[i] + VF[i] + VS[i] + VB[i] - 1);
      o.b  = 1'b0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.pe = 1'b0;
      o.fs = 1'b0;
      return o;
   endfunction

   // Reference model: the n-th tick since reset release shows pixel n-1 of the frame.
   initial forever begin
      exp_t e;
      @(posedge clk or negedge rst);
      if (!rst) begin
         edges = 0;
      end else begin
         edges++;
         for (int i = 0; i < N; i++) begin
            if (edges % CD[i] == 0) begin
               e.inst = i;
               e.o    = model_obs(i, edges / CD[i]);
               sb.push_back(e);
            end
         end
      end
   end

   // Monitor: outputs must equal the popped state on a tick cycle, else hold.
   initial begin
      obs_t last [N];
      obs_t pexp [N];
      bit   pend [N];
      obs_t want;
      obs_t act;
      exp_t e;
      forever begin
         @(negedge clk or negedge rst);
         #1;
         for (int i = 0; i < N; i++) pend[i] = 1'b0;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            pend[e.inst] = 1'b1;
            pexp[e.inst] = e.o;
         end
         for (int i = 0; i < N; i++) begin
            if (!rst) begin
               want    = reset_obs(i);
               last[i] = want;
            end else if (pend[i]) begin
               want       = pexp[i];
               last[i]    = want;
               last[i].pe = 1'b0;
               last[i].fs = 1'b0;
            end else begin
               want = last[i];
            end
            act = '{h: hc[i], v: vc[i], b: br[i], hs: hsy[i], vs: vsy[i], pe: pe[i], fs: fs[i]};
            checks++;
            if (act !== want) begin
               failures++;
               $display("FAIL outputs inst%0d t=%0t got h=%0d v=%0d b=%0b hs=%0b vs=%0b pe=%0b fs=%0b want h=%0d v=%0d b=%0b hs=%0b vs=%0b pe=%0b fs=%0b",
                        i, $time, act.h, act.v, act.b, act.hs, act.vs, act.pe, act.fs,
                        want.h, want.v, want.b, want.hs, want.vs, want.pe, want.fs);
            end
         end
      end
   end

   // Stimulus: power-on reset, long run, then random mid-frame resets.
   initial begin
      obs_t ract;
      int   w;
      #2 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         ract = '{h: hc[i], v: vc[i], b: br[i], hs: hsy[i], vs: vsy[i], pe: pe[i], fs: fs[i]};
         checks++;
         if (ract !== reset_obs(i)) begin
            failures++;
            $display("FAIL reset_state inst%0d t=%0t h=%0d v=%0d b=%0b hs=%0b vs=%0b pe=%0b fs=%0b",
                     i, $time, ract.h, ract.v, ract.b, ract.hs, ract.vs, ract.pe, ract.fs);
         end
      end
      #1 rst = 1'b1;
      w = 0;
      while ((pe[0] !== 1'b1) && (w < 40)) begin
         @(posedge clk);
         #1;
         w++;
      end
      checks++;
      if (pe[0] !== 1'b1) begin
         failures++;
         $display("FAIL timeout waiting for first pix_en t=%0t", $time);
      end
      repeat (7000) @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         repeat ($urandom_range(4000, 50)) @(posedge clk);
         #2 rst = 1'b0;
         repeat ($urandom_range(4, 1)) @(posedge clk);
         #2 rst = 1'b1;
      end
      repeat (8000) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
